// File: rtl/ppu_pkg.sv
// Shared definitions for the tile post-processing / quantization unit:
// state encoding, fixed-point constants and saturation helpers.
package ppu_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RECIP = 2'd1,
        ST_DRAIN = 2'd2
    } ppu_state_t;

    localparam int Q_FRAC       = 8;   // fraction bits of the Q8.8 scale
    localparam int FRAC_DEFAULT = 13;  // fraction bits of the reciprocal

    function automatic logic [63:0] sat_unsigned(input logic [63:0] v,
                                                 input logic [63:0] max_val);
        return (v > max_val) ? max_val : v;
    endfunction

    // Clamp a signed value into [0, max_val].
    function automatic logic [63:0] relu_sat(input logic signed [63:0] y,
                                             input logic [63:0] max_val);
        if (y < 64'sd0) return 64'd0;
        return sat_unsigned($unsigned(y), max_val);
    endfunction

endpackage

// File: rtl/ppu_tile_quant_if.sv
// Row-streaming bus of the tile quantizer: input rows with per-beat scale/bias,
// output quantized rows with the tile max.
interface ppu_tile_quant_if #(
    parameter int LANES = 16,
    parameter int IN_W  = 24,
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
);
    logic [15:0]            scale;
    logic [15:0]            bias;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [ACC_W-1:0]       out_max;
    logic                   out_last;

    modport master (
        output scale, bias, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_max, out_last
    );

    modport slave (
        input  scale, bias, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_max, out_last
    );
endinterface

// File: rtl/ppu_tile_quant_recip_div.sv
// Iterative restoring divider, one quotient bit per clock (W cycles);
// a zero divisor returns all ones after a single cycle.
module ppu_recip_div #(
    parameter int W     = 21,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [W-1:0]     quotient
);
    localparam int CNT_W = $clog2(W);

    logic             active_reg;
    logic             zero_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     dvd_reg;
    logic [W-1:0]     quo_reg;
    logic [DIV_W-1:0] dsr_reg;
    logic [DIV_W-1:0] rem_reg;
    logic [DIV_W:0]   rem_shift;
    logic [DIV_W:0]   rem_sub;

    assign rem_shift = {rem_reg, dvd_reg[W-1]};
    assign rem_sub   = rem_shift - {1'b0, dsr_reg};
    // High in the cycle whose closing edge writes the final quotient bit.
    assign done      = active_reg && (zero_reg || cnt_reg == CNT_W'(W-1));
    assign quotient  = quo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg <= 1'b0;
            zero_reg   <= 1'b0;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            quo_reg    <= '0;
            dsr_reg    <= '0;
            rem_reg    <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            zero_reg   <= (divisor == '0);
            cnt_reg    <= '0;
            dvd_reg    <= dividend;
            dsr_reg    <= divisor;
            rem_reg    <= '0;
            quo_reg    <= (divisor == '0) ? '1 : '0;
        end else if (active_reg) begin
            if (!zero_reg) begin
                if (!rem_sub[DIV_W]) begin
                    rem_reg <= rem_sub[DIV_W-1:0];
                    quo_reg <= {quo_reg[W-2:0], 1'b1};
                end else begin
                    rem_reg <= rem_shift[DIV_W-1:0];
                    quo_reg <= {quo_reg[W-2:0], 1'b0};
                end
                dvd_reg <= dvd_reg << 1;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (done) active_reg <= 1'b0;
        end
    end
endmodule

// File: rtl/ppu_tile_quant.sv
// Tile post-processor: scale/bias/ReLU/saturate rows into a buffer, divide for the
// tile reciprocal, then stream quantized rows. PPU_ROUND_EN selects rounding shifts.
module ppu_tile_quant
    import ppu_pkg::*;
#(
    parameter int LANES = 16,
    parameter int IN_W  = 24,
    parameter int ACC_W = 16,
    parameter int ROWS  = 16,
    parameter int OUT_W = 8,
    parameter int FRAC  = FRAC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    ppu_tile_quant_if.slave  bus,
    output logic             busy
);
    localparam int RECIP_W = OUT_W + FRAC;
    localparam int ADDR_W  = $clog2(ROWS);
    localparam int CNT_W   = $clog2(ROWS + 1);
    localparam int PROD_W  = IN_W + 17;
    localparam int Y_W     = PROD_W + 1;
    localparam int Q_W     = ACC_W + RECIP_W + 1;
    localparam logic [63:0]        ACC_MAX  = (64'd1 << ACC_W) - 64'd1;
    localparam logic [63:0]        OUT_MAX  = (64'd1 << OUT_W) - 64'd1;
    localparam logic [RECIP_W-1:0] DIVIDEND = RECIP_W'(((1 << OUT_W) - 1) << FRAC);

    ppu_state_t              state_reg;
    logic                    in_ready_reg, busy_reg;
    logic [ADDR_W-1:0]       wr_ptr_reg;
    logic [CNT_W-1:0]        n_reg, fetch_ptr_reg, rd_idx_reg;
    logic [ACC_W-1:0]        max_reg, max_next, row_max;
    logic                    rd_valid_reg, out_valid_reg, out_last_reg;
    logic [LANES*ACC_W-1:0]  rd_data_reg, row_y;
    logic [LANES*OUT_W-1:0]  out_data_reg, row_q;
    logic [ACC_W-1:0]        lane_y [LANES];
    logic                    in_fire, accept_last, out_fire, b_load, fetch_en;
    logic                    div_done;
    logic [RECIP_W-1:0]      recip;

    logic [LANES*ACC_W-1:0]  buf_mem [ROWS];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [IN_W-1:0]   x;
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] p;
        logic signed [Y_W-1:0]    y;
        logic [Q_W-1:0]           qprod;
        logic [Q_W-1:0]           qsh;

        assign x    = bus.in_data[gi*IN_W +: IN_W];
        assign prod = PROD_W'(x) * PROD_W'($signed({1'b0, bus.scale}));
`ifdef PPU_ROUND_EN
        assign p    = (prod + PROD_W'(128)) >>> Q_FRAC;
`else
        assign p    = prod >>> Q_FRAC;
`endif
        assign y    = Y_W'(p) + Y_W'($signed(bus.bias));
        assign lane_y[gi] = ACC_W'(relu_sat(64'(y), ACC_MAX));
        assign row_y[gi*ACC_W +: ACC_W] = lane_y[gi];

        assign qprod = Q_W'(rd_data_reg[gi*ACC_W +: ACC_W]) * Q_W'(recip);
`ifdef PPU_ROUND_EN
        assign qsh   = (qprod + Q_W'(1 << (FRAC - 1))) >> FRAC;
`else
        assign qsh   = qprod >> FRAC;
`endif
        assign row_q[gi*OUT_W +: OUT_W] = OUT_W'(sat_unsigned(64'(qsh), OUT_MAX));
    end

    always_comb begin
        row_max = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_y[i] > row_max) row_max = lane_y[i];
        end
    end
    assign max_next = (row_max > max_reg) ? row_max : max_reg;

    assign in_fire     = (state_reg == ST_FILL) && in_ready_reg && bus.in_valid;
    assign accept_last = in_fire && (bus.in_last || wr_ptr_reg == ADDR_W'(ROWS - 1));
    // Two-stage drain: registered buffer read, then registered quantized row.
    assign out_fire = out_valid_reg && bus.out_ready;
    assign b_load   = rd_valid_reg && (!out_valid_reg || bus.out_ready);
    assign fetch_en = (state_reg == ST_DRAIN) && (fetch_ptr_reg < n_reg)
                      && (!rd_valid_reg || b_load);

    ppu_recip_div #(.W(RECIP_W), .DIV_W(ACC_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept_last),
        .dividend (DIVIDEND),
        .divisor  (max_next),
        .done     (div_done),
        .quotient (recip)
    );

    always_ff @(posedge clk) begin
        if (in_fire) buf_mem[wr_ptr_reg] <= row_y;
        if (fetch_en) rd_data_reg <= buf_mem[fetch_ptr_reg[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_FILL;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            wr_ptr_reg    <= '0;
            n_reg         <= '0;
            max_reg       <= '0;
            fetch_ptr_reg <= '0;
            rd_idx_reg    <= '0;
            rd_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_FILL: begin
                    in_ready_reg <= 1'b1;
                    if (in_fire) begin
                        max_reg    <= max_next;
                        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                        if (accept_last) begin
                            state_reg    <= ST_RECIP;
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b1;
                            n_reg        <= CNT_W'(wr_ptr_reg) + CNT_W'(1);
                            wr_ptr_reg   <= '0;
                        end
                    end
                end
                ST_RECIP: begin
                    fetch_ptr_reg <= '0;
                    if (div_done) state_reg <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fetch_en) begin
                        fetch_ptr_reg <= fetch_ptr_reg + CNT_W'(1);
                        rd_idx_reg    <= fetch_ptr_reg;
                        rd_valid_reg  <= 1'b1;
                    end else if (b_load) begin
                        rd_valid_reg  <= 1'b0;
                    end
                    if (b_load) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= row_q;
                        out_last_reg  <= (rd_idx_reg == n_reg - CNT_W'(1));
                    end else if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                    end
                    if (out_fire && out_last_reg) begin
                        state_reg     <= ST_FILL;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                        max_reg       <= '0;
                        fetch_ptr_reg <= '0;
                        rd_valid_reg  <= 1'b0;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                    end
                end
                default: state_reg <= ST_FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_max   = max_reg;
    assign busy          = busy_reg;
endmodule

// File: tb/tb_ppu_tile_quant.sv
// Directed + random tiles against an arithmetic reference model of ppu_tile_quant.
module tb_ppu_tile_quant;
    localparam int LANES   = 16;
    localparam int IN_W    = 24;
    localparam int ACC_W   = 16;
    localparam int ROWS    = 16;
    localparam int OUT_W   = 8;
    localparam int FRAC    = 13;
    localparam int RECIP_W = OUT_W + FRAC;
    localparam int TMO     = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    ppu_tile_quant_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    ppu_tile_quant #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .ROWS(ROWS), .OUT_W(OUT_W), .FRAC(FRAC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int     tx     [ROWS][LANES];
    int     tscale [ROWS];
    int     tbias  [ROWS];
    longint exp_st [ROWS][LANES];
    longint exp_max;
    longint exp_recip;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Floor division by 256 of a signed product, then bias, ReLU and clamp.
    function automatic longint ref_store(longint x, longint sc, longint bs);
        longint v, p, y;
        v = x * sc;
`ifdef PPU_ROUND_EN
        v = v + 128;
`endif
        p = (v >= 0) ? v / 256 : -((-v + 255) / 256);
        y = p + bs;
        if (y < 0) y = 0;
        if (y > 65535) y = 65535;
        return y;
    endfunction

    function automatic longint ref_quant(longint s, longint r);
        longint q;
        q = s * r;
`ifdef PPU_ROUND_EN
        q = q + 4096;
`endif
        q = q / 8192;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_out_data"},  128'(bus.out_data),  128'(0));
        check({tag, "_out_last"},  128'(bus.out_last),  128'(0));
        check({tag, "_out_max"},   128'(bus.out_max),   128'(0));
        check({tag, "_busy"},      128'(busy),          128'(0));
        check({tag, "_in_ready"},  128'(bus.in_ready),  128'(0));
    endtask

    // Sends n rows from tx/tscale/tbias, then drains them. stall_beat gets out_ready
    // held low for 5 cycles; abort_beat returns as soon as that beat is presented.
    task automatic run_tile(input string name, input int n, input bit explicit_last,
                            input int stall_beat, input int abort_beat);
        logic [LANES*IN_W-1:0]  d;
        logic [LANES*OUT_W-1:0] expv;
        int t, lat, exp_lat;
        exp_max = 0;
        for (int r = 0; r < n; r++)
            for (int l = 0; l < LANES; l++) begin
                exp_st[r][l] = ref_store(longint'(tx[r][l]), longint'(tscale[r]), longint'(tbias[r]));
                if (exp_st[r][l] > exp_max) exp_max = exp_st[r][l];
            end
        exp_recip = (exp_max == 0) ? ((longint'(1) << RECIP_W) - 1) : ((longint'(255) << FRAC) / exp_max);
        exp_lat   = (exp_max == 0) ? 3 : RECIP_W + 2;

        for (int r = 0; r < n; r++) begin
            for (int l = 0; l < LANES; l++) d[l*IN_W +: IN_W] = IN_W'(tx[r][l]);
            bus.scale    = 16'(tscale[r]);
            bus.bias     = 16'(tbias[r]);
            bus.in_data  = d;
            bus.in_last  = explicit_last && (r == n - 1);
            bus.in_valid = 1'b1;
            t = 0;
            while (!bus.in_ready && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check({name, "_in_ready_timeout"}, 128'(0), 128'(1));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({name, "_busy_recip"},   128'(busy),         128'(1));
        check({name, "_in_ready_low"}, 128'(bus.in_ready), 128'(0));

        lat = 0;
        while (!bus.out_valid && lat < TMO) begin @(negedge clk); lat++; end
        check({name, "_latency"}, 128'(lat), 128'(exp_lat));

        for (int b = 0; b < n; b++) begin
            for (int l = 0; l < LANES; l++) expv[l*OUT_W +: OUT_W] = OUT_W'(ref_quant(exp_st[b][l], exp_recip));
            t = 0;
            while (!bus.out_valid && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) check({name, "_out_valid_timeout"}, 128'(0), 128'(1));
            if (b == abort_beat) return;
            if (b == stall_beat) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check({name, "_stall_data"}, 128'(bus.out_data), 128'(expv));
                end
                check({name, "_stall_valid"}, 128'(bus.out_valid), 128'(1));
                bus.out_ready = 1'b1;
            end
            check({name, "_data"}, 128'(bus.out_data), 128'(expv));
            check({name, "_last"}, 128'(bus.out_last), 128'(b == n - 1));
            check({name, "_max"},  128'(bus.out_max),  128'(exp_max));
            $display("%s beat %0d data=%h last=%0d max=%0d", name, b, bus.out_data, bus.out_last, bus.out_max);
            @(negedge clk);
        end
        check({name, "_done_valid"},    128'(bus.out_valid), 128'(0));
        check({name, "_done_in_ready"}, 128'(bus.in_ready),  128'(1));
        check({name, "_done_busy"},     128'(busy),          128'(0));
    endtask

    task automatic fill_const(input int n, input int x, input int sc, input int bs);
        for (int r = 0; r < n; r++) begin
            tscale[r] = sc;
            tbias[r]  = bs;
            for (int l = 0; l < LANES; l++) tx[r][l] = x;
        end
    endtask

    initial begin
        bus.scale     = '0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready_rise", 128'(bus.in_ready), 128'(1));

        // Full tile with no in_last: ROWS-th beat ends the tile.
        fill_const(16, 1000, 16'h0100, 0);
        run_tile("full16", 16, 1'b0, -1, -1);

        // Negative lane clipped by ReLU, single positive lane sets the max.
        fill_const(2, 0, 16'h0100, 10);
        for (int r = 0; r < 2; r++) begin tx[r][3] = -500; tx[r][0] = 200; end
        run_tile("relu", 2, 1'b1, -1, -1);

        fill_const(3, 1 << 22, 16'h0400, 0);
        run_tile("sat", 3, 1'b1, -1, -1);

        fill_const(3, 0, 16'h0100, 0);
        run_tile("zero", 3, 1'b1, -1, -1);

        fill_const(4, 0, 16'h0100, 0);
        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++) tx[r][l] = int'($urandom_range(0, 60000)) - 10000;
        run_tile("stall", 4, 1'b1, 2, -1);

        for (int k = 0; k < 3; k++) begin
            int n;
            n = int'($urandom_range(1, 16));
            for (int r = 0; r < n; r++) begin
                tscale[r] = int'($urandom_range(0, 1023));
                tbias[r]  = int'($urandom_range(0, 400)) - 200;
                for (int l = 0; l < LANES; l++) tx[r][l] = int'($urandom_range(0, 200000)) - 100000;
            end
            run_tile($sformatf("rand%0d", k), n, (n < 16) ? 1'b1 : 1'($urandom_range(0, 1)), -1, -1);
        end

        // Abort mid-drain, then a single-row tile must show no residue.
        fill_const(8, 0, 16'h0100, 0);
        for (int r = 0; r < 8; r++)
            for (int l = 0; l < LANES; l++) tx[r][l] = int'($urandom_range(100, 30000));
        run_tile("abort", 8, 1'b1, -1, 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_const(1, 50, 16'h0100, 0);
        run_tile("after_rst", 1, 1'b1, -1, -1);
        check("after_rst_max_model", 128'(exp_max), 128'(50));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
